// File: rtl/okand_op_sched.sv
// Serial-link operation scheduler: deserialises opcode/A/B, runs one ALU op, serialises the result.
// Optional build macro OKAND_PARITY_EN appends an even-parity bit to every transmitted result.
module okand_op_sched #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPC_W = 4
) (
  input  logic       pc_clk,
  input  logic       pc_rst,
  input  logic       pc_data,
  input  logic       pc_valid,
  output logic       fpga_data,
  output logic       fpga_valid,
  output logic       fpga_busy,
  output logic       err_overrun,
  output logic       err_opcode,
  output logic [7:0] frame_cnt
);

`ifdef OKAND_PARITY_EN
  localparam int unsigned TxLen = WIDTH + 1;
`else
  localparam int unsigned TxLen = WIDTH;
`endif
  localparam int unsigned MaxLen = (OPC_W > TxLen) ? OPC_W : TxLen;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);

  localparam logic [OPC_W-1:0] OpcAnd = OPC_W'(0);
  localparam logic [OPC_W-1:0] OpcOr  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OpcXor = OPC_W'(2);
  localparam logic [OPC_W-1:0] OpcAdd = OPC_W'(3);
  localparam logic [OPC_W-1:0] OpcSub = OPC_W'(4);

  typedef enum logic [2:0] {StRxOpc, StRxA, StRxB, StExec, StTx} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [OPC_W-1:0]  opc_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [TxLen-1:0]  tx_q;
  logic [TxLen-1:0]  tx_word;
  logic [WIDTH-1:0]  result;
  logic              illegal;
  logic              err_overrun_q, err_opcode_q;
  logic [7:0]        frame_cnt_q;
  logic              last_opc, last_a, last_b, last_tx;

  assign last_opc = (cnt_q == CntW'(OPC_W - 1));
  assign last_a   = (cnt_q == CntW'(WIDTH - 1));
  assign last_b   = last_a;
  assign last_tx  = (cnt_q == CntW'(TxLen - 1));

  // State register
  always_ff @(posedge pc_clk) begin
    if (pc_rst) begin
      state_q <= StRxOpc;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state; the field counter restarts on every state change
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRxOpc: begin
        if (pc_valid) begin
          if (last_opc) begin
            state_d = StRxA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StRxA: begin
        if (pc_valid) begin
          if (last_a) begin
            state_d = StRxB;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StRxB: begin
        if (pc_valid) begin
          if (last_b) begin
            state_d = StExec;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StExec: begin
        state_d = StTx;
        cnt_d   = '0;
      end
      StTx: begin
        if (last_tx) begin
          state_d = StRxOpc;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StRxOpc;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from state only, so they are all 0 the cycle after reset
  always_comb begin
    fpga_busy  = 1'b0;
    fpga_valid = 1'b0;
    fpga_data  = 1'b0;
    unique case (state_q)
      StExec: fpga_busy = 1'b1;
      StTx: begin
        fpga_busy  = 1'b1;
        fpga_valid = 1'b1;
        fpga_data  = tx_q[0];
      end
      default: ;
    endcase
  end

  // ALU; illegal opcodes produce 0
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (opc_q)
      OpcAnd:  result = a_q & b_q;
      OpcOr:   result = a_q | b_q;
      OpcXor:  result = a_q ^ b_q;
      OpcAdd:  result = a_q + b_q;
      OpcSub:  result = a_q - b_q;
      default: illegal = 1'b1;
    endcase
  end

`ifdef OKAND_PARITY_EN
  // Illegal opcode forces parity 1, which is wrong for a zero result
  assign tx_word = {(illegal ? 1'b1 : ^result), result};
`else
  assign tx_word = result;
`endif

  // Datapath: LSB-first shift-in of fields, shift-out of the result
  always_ff @(posedge pc_clk) begin
    if (pc_rst) begin
      opc_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      tx_q          <= '0;
      err_overrun_q <= 1'b0;
      err_opcode_q  <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      if (pc_valid) begin
        unique case (state_q)
          StRxOpc: opc_q <= {pc_data, opc_q[OPC_W-1:1]};
          StRxA:   a_q   <= {pc_data, a_q[WIDTH-1:1]};
          StRxB:   b_q   <= {pc_data, b_q[WIDTH-1:1]};
          default: err_overrun_q <= 1'b1;
        endcase
      end
      if (state_q == StExec) begin
        tx_q <= tx_word;
        if (illegal) err_opcode_q <= 1'b1;
      end else if (state_q == StTx) begin
        tx_q <= tx_q >> 1;
        if (last_tx) frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign err_overrun = err_overrun_q;
  assign err_opcode  = err_opcode_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_okand_op_sched.sv
// Randomised self-checking bench for okand_op_sched against a frame-level reference model.
module tb_okand_op_sched;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned OPC_W = 4;
`ifdef OKAND_PARITY_EN
  localparam int unsigned TxLen = WIDTH + 1;
`else
  localparam int unsigned TxLen = WIDTH;
`endif

  logic       pc_clk = 1'b0;
  logic       pc_rst, pc_data, pc_valid;
  logic       fpga_data, fpga_valid, fpga_busy, err_overrun, err_opcode;
  logic [7:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int exp_frames  = 0;
  bit exp_ovr     = 1'b0;
  bit exp_opc_err = 1'b0;

  okand_op_sched #(.WIDTH(WIDTH), .OPC_W(OPC_W)) dut (
    .pc_clk      (pc_clk),
    .pc_rst      (pc_rst),
    .pc_data     (pc_data),
    .pc_valid    (pc_valid),
    .fpga_data   (fpga_data),
    .fpga_valid  (fpga_valid),
    .fpga_busy   (fpga_busy),
    .err_overrun (err_overrun),
    .err_opcode  (err_opcode),
    .frame_cnt   (frame_cnt)
  );

  always #5 pc_clk = ~pc_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pc_clk);
    #1;
  endtask

  function automatic longint ref_op(input int opc, input longint a, input longint b);
    longint m;
    m = (longint'(1) << WIDTH);
    case (opc)
      0:       return a & b;
      1:       return a | b;
      2:       return a ^ b;
      3:       return (a + b) % m;
      4:       return (a - b + m) % m;
      default: return 0;
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"},  fpga_busy,   0);
    check_eq({tag, "_valid"}, fpga_valid,  0);
    check_eq({tag, "_data"},  fpga_data,   0);
    check_eq({tag, "_cnt"},   frame_cnt,   exp_frames);
    check_eq({tag, "_eovr"},  err_overrun, exp_ovr);
    check_eq({tag, "_eopc"},  err_opcode,  exp_opc_err);
  endtask

  // Send one frame and follow it cycle by cycle through EXEC and TX.
  // ovr_at / rst_at: TX bit index at which to inject an overrun bit or a reset (-1 = none).
  task automatic run_frame(input int opc, input int a, input int b, input bit gaps,
                           input int ovr_at, input int rst_at);
    logic [OPC_W+2*WIDTH-1:0] frame;
    logic [WIDTH:0]           word;
    longint                   res;
    int                       parity;
    frame = {b[WIDTH-1:0], a[WIDTH-1:0], opc[OPC_W-1:0]};
    res   = ref_op(opc, a, b);
    parity = 0;
    for (int k = 0; k < WIDTH; k++) parity ^= int'((res >> k) & 1);
    if (opc >= 5) parity = 1;
    word = {parity[0], res[WIDTH-1:0]};

    for (int k = 0; k < OPC_W + 2 * WIDTH; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          pc_valid = 1'b0;
          pc_data  = 1'($urandom);
          tick();
        end
      end
      pc_valid = 1'b1;
      pc_data  = frame[k];
      tick();
      if (k == 0) begin
        check_eq("rx_busy", fpga_busy, 0);
        check_eq("rx_valid", fpga_valid, 0);
      end
    end
    pc_valid = 1'b0;
    pc_data  = 1'b0;
    // EXEC cycle
    check_eq("exec_busy", fpga_busy, 1);
    check_eq("exec_valid", fpga_valid, 0);
    check_eq("exec_data", fpga_data, 0);
    tick();
    if (opc >= 5) exp_opc_err = 1'b1;
    for (int i = 0; i < int'(TxLen); i++) begin
      check_eq("tx_valid", fpga_valid, 1);
      check_eq("tx_busy", fpga_busy, 1);
      check_eq($sformatf("tx_bit%0d_opc%0d", i, opc), fpga_data, word[i]);
      if (i == rst_at) begin
        pc_rst   = 1'b1;
        pc_valid = 1'b1;
        pc_data  = 1'b1;
        tick();
        exp_frames  = 0;
        exp_ovr     = 1'b0;
        exp_opc_err = 1'b0;
        check_idle_outputs("after_rst");
        pc_rst   = 1'b0;
        pc_valid = 1'b0;
        pc_data  = 1'b0;
        return;
      end
      if (i == ovr_at) begin
        pc_valid = 1'b1;
        pc_data  = 1'($urandom);
        exp_ovr  = 1'b1;
      end
      tick();
      pc_valid = 1'b0;
      pc_data  = 1'b0;
    end
    exp_frames = (exp_frames + 1) % 256;
    check_idle_outputs("frame_end");
  endtask

  initial begin
    int opc, ovr, a, b;
    pc_rst   = 1'b1;
    pc_valid = 1'b1;
    pc_data  = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    pc_rst   = 1'b0;
    pc_valid = 1'b0;
    pc_data  = 1'b0;
    tick();

    run_frame(0, 'hF0F0, 'hFF00, 1'b0, -1, -1);
    run_frame(3, 'hFFFF, 'h0002, 1'b0, -1, -1);
    run_frame(4, 'h0000, 'h0001, 1'b0, -1, -1);
    run_frame(0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 1'b1, -1, -1);
    run_frame(7, 'h1234, 'h5678, 1'b0, -1, -1);
    run_frame(2, 'hAAAA, 'h0F0F, 1'b0, -1, -1);
    run_frame(1, 'h1111, 'h2222, 1'b0, 3, -1);
    run_frame(0, 'hFFFF, 'h0F0F, 1'b0, -1, -1);
    run_frame(3, 'h1357, 'h2468, 1'b0, -1, 5);
    run_frame(1, 'h00FF, 'hFF00, 1'b0, -1, -1);

    for (int n = 0; n < 24; n++) begin
      opc = int'($urandom_range(0, 15));
      if (n % 3 != 0) opc = int'($urandom_range(0, 4));
      a   = int'($urandom_range(0, 65535));
      b   = int'($urandom_range(0, 65535));
      ovr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TxLen - 1)) : -1;
      run_frame(opc, a, b, 1'($urandom), ovr, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
